// File: rtl/regfile_fwd.sv
// regfile_fwd: multi-port register file with EX/MEM/WB forwarding and load-use stall detection.
// Optional macro REGFILE_FWD_STALL_CNT_EN adds a saturating stall-cycle counter output.
module regfile_fwd #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    input  logic                     ex_we,
    input  logic [ADDR_W-1:0]        ex_waddr,
    input  logic [DATA_W-1:0]        ex_wdata,
    input  logic                     ex_is_load,
    input  logic                     mem_we,
    input  logic [ADDR_W-1:0]        mem_waddr,
    input  logic [DATA_W-1:0]        mem_wdata,
    input  logic                     wb_we,
    input  logic [ADDR_W-1:0]        wb_waddr,
    input  logic [DATA_W-1:0]        wb_wdata,
    output logic                     stall_req
`ifdef REGFILE_FWD_STALL_CNT_EN
    ,
    output logic [15:0]              stall_cnt
`endif
);
    logic [DATA_W-1:0] regs [2**ADDR_W];
    logic [NUM_RD-1:0] hz;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
        end else if (wb_we && wb_waddr != '0) begin
            regs[wb_waddr] <= wb_wdata;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = raddr[g*ADDR_W +: ADDR_W];
        assign hz[g] = re[g] && ra != '0 && ex_we && ex_is_load && ex_waddr == ra;
        // a load in EX has no data yet, so its port falls through to older producers
        assign rdata[g*DATA_W +: DATA_W] =
            (rst || !re[g] || ra == '0)             ? '0        :
            (ex_we && ex_waddr == ra && !ex_is_load) ? ex_wdata  :
            (mem_we && mem_waddr == ra)             ? mem_wdata :
            (wb_we && wb_waddr == ra)               ? wb_wdata  :
                                                      regs[ra];
    end

    assign stall_req = !rst && |hz;

`ifdef REGFILE_FWD_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) stall_cnt <= '0;
        else if (stall_req && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule

// File: doc/regfile_fwd.md
Name: regfile_fwd

Overview:
Parametrised successor to the two-port register file used by the five-stage core. It provides NUM_RD read ports, integrated forwarding from the EX, MEM and WB stages, and load-use hazard detection with a stall request to the pipeline controller. It sits between ID and WB and replaces the plain regfile plus external bypass muxing. ID consumes its read data directly.

Parameters:
DATA_W, 32, register and data width in bits
ADDR_W, 5, register address width; the array has 2**ADDR_W entries
NUM_RD, 2, number of independent read ports (1..4)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
re  in  NUM_RD  per-port read enable
raddr  in  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
rdata  out  NUM_RD*DATA_W  read data, port i at bits [i*DATA_W +: DATA_W]
ex_we  in  1  EX-stage result will write a register
ex_waddr  in  ADDR_W  EX-stage destination
ex_wdata  in  DATA_W  EX-stage result
ex_is_load  in  1  EX-stage instruction is a load; data is not yet valid
mem_we  in  1  MEM-stage write pending
mem_waddr  in  ADDR_W  MEM-stage destination
mem_wdata  in  DATA_W  MEM-stage result
wb_we  in  1  architectural write enable
wb_waddr  in  ADDR_W  write address
wb_wdata  in  DATA_W  write data
stall_req  out  1  load-use hazard; ID must hold and insert a bubble

Behaviour:
- One clock domain; reset is synchronous and active-high (clk, rst).
- Reset: every array entry is cleared to 0 on the clk edge with rst=1. While rst=1, all rdata = 0 and stall_req = 0.
- Write: at posedge, if !rst && wb_we && wb_waddr != 0, then array[wb_waddr] <= wb_wdata. Writes to register 0 are dropped. Register 0 always reads 0.
- Read is combinational with zero latency. The value for port i is chosen by the first matching rule in this priority order:
  1. rst or !re[i] or raddr_i == 0 -> 0
  2. ex_we && ex_waddr == raddr_i && !ex_is_load -> ex_wdata
  3. mem_we && mem_waddr == raddr_i -> mem_wdata
  4. wb_we && wb_waddr == raddr_i -> wb_wdata (write-through in the same cycle)
  5. otherwise -> array[raddr_i]
- Youngest producer wins. EX beats MEM, which beats WB, which beats the array.
- Load-use hazard: for any port i, if re[i] && raddr_i != 0 && ex_we && ex_is_load && ex_waddr == raddr_i, then stall_req = 1. That port skips rule 2 and falls through to rules 3-5. Its data is stale and is discarded by ID on a stall.
- stall_req is the OR across ports and is purely combinational. The block holds no hazard state. The stall deasserts once the load advances to MEM and rule 3 supplies the data.
- Write and read of the same address in one cycle: the read returns wb_wdata via rule 4. The array holds it from the next cycle onward.
- All ports are independent. Identical addresses on several ports return identical data.
- Reset mid-operation: a pending WB write in the reset cycle is discarded.

Optional Feature:
Macro REGFILE_FWD_STALL_CNT_EN.
- Defined: adds output stall_cnt [15:0]. It is a saturating counter of cycles with stall_req = 1. It increments at posedge when stall_req && !rst, holds at 16'hFFFF, and clears to 0 on rst.
- Undefined: neither the port nor the counter exists, and the rest of the behaviour is identical.

Test Plan:
- Reset then read: rst=1 for 2 cycles, then read r1..r31 with no writes -> all rdata = 0, stall_req = 0.
- Write/readback: WB writes r5=32'h1234_5678; next cycle port0 reads r5 -> 32'h1234_5678. WB writes r0=32'hFFFF_FFFF -> r0 still reads 0.
- Forward priority: array r3=1, with same-cycle WB r3=2, MEM r3=3, EX r3=4 (non-load) -> port0 returns 4. Drop EX -> 3. Drop MEM -> 2. Drop WB -> 1.
- Load-use: ex_is_load=1, ex_waddr=7, port1 reads r7 -> stall_req = 1. Next cycle with mem_waddr=7, mem_wdata=32'hCAFE_0000 and EX idle -> stall_req = 0, rdata1 = 32'hCAFE_0000.
- Multi-port (NUM_RD=4): ports read r2, r2, r0, r9 with MEM r2=32'hA5, re[3]=0 -> rdata = A5, A5, 0, 0.
- REGFILE_FWD_STALL_CNT_EN: hold the load-use condition for 70000 cycles -> stall_cnt = 16'hFFFF. Apply rst -> stall_cnt = 0.
